// File: rtl/fft_bin_bar_scaler.sv
// rtl/fft_bin_bar_scaler.sv - FFT bins to peak-hold histogram bar heights
// One bin per cycle through a shared magnitude datapath; all bars commit together.
module fft_bin_bar_scaler #(
  parameter int NUM_BINS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT      = 11,
  parameter int MAX_HEIGHT = 24,
  parameter int DECAY      = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [NUM_BINS*DATA_WIDTH-1:0] frequency_bins,
  output logic                           in_ready,
  output logic [NUM_BINS*DATA_WIDTH-1:0] bar_heights,
  output logic                           out_valid
);

  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_BINS - 1);
  localparam logic [17:0]           MAX_H18  = 18'(MAX_HEIGHT);
  localparam logic [DATA_WIDTH-1:0] MAX_W    = DATA_WIDTH'(MAX_HEIGHT);
  localparam logic [DATA_WIDTH-1:0] DECAY_W  = DATA_WIDTH'(DECAY);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t                          state_q;
  logic [IDX_W-1:0]                idx_q;
  logic [NUM_BINS*DATA_WIDTH-1:0]  snap_q;
  logic [NUM_BINS*DATA_WIDTH-1:0]  shadow_q;
  logic [NUM_BINS*DATA_WIDTH-1:0]  bars_q;
  logic                            out_valid_q;

  // 17-bit magnitude so that -32768 maps to +32768 without wrapping.
  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic [16:0] e;
    e = {v[15], v};
    return v[15] ? (17'd0 - e) : e;
  endfunction

  logic [DATA_WIDTH-1:0] bin_w;
  logic [16:0]           a, b, mx, mn;
  logic [17:0]           mag, scaled;
  logic [DATA_WIDTH-1:0] s_w, h_w, d_w, res_w;

  always_comb begin
    bin_w  = snap_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    a      = abs17(bin_w[31:16]);
    b      = abs17(bin_w[15:0]);
    mx     = (a > b) ? a : b;
    mn     = (a > b) ? b : a;
    mag    = {1'b0, mx} + {2'b00, mn[16:1]};
    scaled = mag >> SHIFT;
    s_w    = (scaled > MAX_H18) ? MAX_W : DATA_WIDTH'(scaled);
    h_w    = bars_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    d_w    = (h_w > DECAY_W) ? (h_w - DECAY_W) : '0;
    res_w  = (s_w > d_w) ? s_w : d_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      shadow_q    <= '0;
      bars_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            snap_q  <= frequency_bins;
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          shadow_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= res_w;
          if (idx_q == LAST_IDX) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        COMMIT: begin
          bars_q      <= shadow_q;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign bar_heights = bars_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fft_bin_bar_scaler.sv
// tb/tb_fft_bin_bar_scaler.sv - self-checking bench for fft_bin_bar_scaler
// Inputs change and outputs are sampled on the falling edge.
module tb_fft_bin_bar_scaler;

  localparam int NB = 8;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [NB*DW-1:0]  frequency_bins;
  logic              in_ready;
  logic [NB*DW-1:0]  bar_heights;
  logic              out_valid;

  int total = 0;
  int bad   = 0;
  int model [NB];
  int last  [NB];

  fft_bin_bar_scaler dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .frequency_bins (frequency_bins),
    .in_ready       (in_ready),
    .bar_heights    (bar_heights),
    .out_valid      (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bar height from first principles: |re|,|im|, alpha-max-beta-min, scale, clamp, peak hold.
  function automatic int ref_height(input logic [31:0] w, input int h);
    logic signed [15:0] r, i;
    int re, im, a, b, mx, mn, s, d;
    r  = w[31:16];
    i  = w[15:0];
    re = r;
    im = i;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    s  = (mx + mn / 2) / 2048;
    if (s > 24) s = 24;
    d  = (h > 1) ? h - 1 : 0;
    return (s > d) ? s : d;
  endfunction

  function automatic logic [31:0] rand_bin();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return {16'h8000, 16'($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF)};
      2: return {16'($urandom_range(0, 8191)), 16'($urandom_range(0, 8191))};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [NB*DW-1:0] rand_frame();
    logic [NB*DW-1:0] f;
    for (int i = 0; i < NB; i++) f[i*DW +: DW] = rand_bin();
    return f;
  endfunction

  function automatic logic [NB*DW-1:0] mk3(input logic [31:0] b0, input logic [31:0] b1,
                                           input logic [31:0] b2);
    logic [NB*DW-1:0] f;
    f = '0;
    f[31:0]  = b0;
    f[63:32] = b1;
    f[95:64] = b2;
    return f;
  endfunction

  // Called at a falling edge with the DUT idle; ends at the falling edge of the result cycle.
  task automatic run_frame(input logic [NB*DW-1:0] f, input bit busy);
    int exp [NB];
    check("accept_rdy", {31'd0, in_ready}, 32'd1);
    in_valid       = 1'b1;
    frequency_bins = f;
    for (int i = 0; i < NB; i++) exp[i] = ref_height(f[i*DW +: DW], model[i]);
    for (int k = 1; k <= NB + 2; k++) begin
      @(negedge clk);
      check("lat_out_valid", {31'd0, out_valid}, (k == NB + 2) ? 32'd1 : 32'd0);
      check("lat_in_ready", {31'd0, in_ready}, (k == NB + 2) ? 32'd1 : 32'd0);
      if (k < NB + 2) begin
        in_valid       = busy;
        frequency_bins = rand_frame();
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      check($sformatf("bar%0d", i), bar_heights[i*DW +: DW], exp[i]);
      model[i] = exp[i];
      last[i]  = bar_heights[i*DW +: DW];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  logic [NB*DW-1:0] f1;

  initial begin
    f1 = mk3({16'h4000, 16'h0000}, {16'hE000, 16'h1000}, {16'h8000, 16'h8000});
    for (int i = 0; i < NB; i++) model[i] = 0;

    reset          = 1'b1;
    in_valid       = 1'($urandom);
    frequency_bins = rand_frame();
    @(posedge clk);
    in_valid       = 1'($urandom);
    frequency_bins = rand_frame();
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < NB; i++) check("rst_bar", bar_heights[i*DW +: DW], 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;

    run_frame(f1, 1'b0);
    check("f1_b0", last[0], 32'd8);
    check("f1_b1", last[1], 32'd5);
    check("f1_b2", last[2], 32'd24);
    run_frame('0, 1'b0);
    check("dec_b0", last[0], 32'd7);
    check("dec_b2", last[2], 32'd23);
    run_frame(mk3({16'h7000, 16'h0000}, 32'd0, 32'd0), 1'b0);
    check("hold_b0", last[0], 32'd14);
    check("hold_b1", last[1], 32'd3);
    check("hold_b2", last[2], 32'd22);

    idle(1);
    run_frame(rand_frame(), 1'b1);
    idle(12);

    // Continuous in_valid with a constant frame: pulses every NB+2 cycles only.
    in_valid       = 1'b1;
    frequency_bins = f1;
    for (int c = 1; c <= 4 * (NB + 2); c++) begin
      @(negedge clk);
      check("cont_out_valid", {31'd0, out_valid}, (c % (NB + 2) == 0) ? 32'd1 : 32'd0);
      if (c % (NB + 2) == 0) begin
        for (int i = 0; i < NB; i++) begin
          model[i] = ref_height(f1[i*DW +: DW], model[i]);
          check("cont_bar", bar_heights[i*DW +: DW], model[i]);
        end
      end
      if (c == 4 * (NB + 2)) in_valid = 1'b0;
    end
    idle(2);

    // Reset during CALC aborts the frame.
    in_valid       = 1'b1;
    frequency_bins = f1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      if (k == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid2", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < NB; i++) begin
      check("abort_bar", bar_heights[i*DW +: DW], 32'd0);
      model[i] = 0;
    end
    idle(12);
    run_frame(f1, 1'b0);
    check("post_b0", last[0], 32'd8);
    check("post_b1", last[1], 32'd5);
    check("post_b2", last[2], 32'd24);

    for (int n = 0; n < 25; n++) begin
      idle($urandom_range(0, 2));
      run_frame(rand_frame(), 1'($urandom_range(0, 1)));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bin_bar_scaler.md
# fft_bin_bar_scaler

Converts one frame of complex FFT bins into bar heights for the histogram display. It sits between the `N_point_fft_seq` output (`outputs` / `out_valid`) and the `frequency_bins` input of `complex_graphics_controller`. It computes an alpha-max-beta-min magnitude per bin, scales and clamps it to the screen's block-row range, and applies peak-hold decay. All bars update together, once per frame, in a single cycle.

## Interface
- `NUM_BINS`, 8: bins per frame; ≥ 2.
- `DATA_WIDTH`, 32: width of each bin word and each bar word.
- `SHIFT`, 11: right shift applied to the magnitude.
- `MAX_HEIGHT`, 24: clamp ceiling for bar height, in 20-pixel block rows (480/20).
- `DECAY`, 1: maximum fall of a bar per frame.

Ports:
- `clk`, in, 1: single clock. One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: frame present on `frequency_bins` this cycle.
- `frequency_bins`, in, NUM_BINS×DATA_WIDTH: bin i real part = [31:16], imag part = [15:0], both signed two's complement.
- `in_ready`, out, 1: high only in IDLE; a frame is accepted when `in_valid && in_ready`.
- `bar_heights`, out, NUM_BINS×DATA_WIDTH: committed bar heights, unsigned, zero-extended, each ≤ MAX_HEIGHT.
- `out_valid`, out, 1: one-cycle pulse, coincident with the first cycle that new `bar_heights` are visible.

## Operation
- FSM states: IDLE, CALC, COMMIT.
  - IDLE, on accept: snapshot all bins into an internal register, set idx=0, go to CALC.
  - CALC: process bin idx, writing the shadow result. After idx = NUM_BINS-1, go to COMMIT.
  - COMMIT: at the closing edge, `bar_heights` <= shadow, `out_valid` <= 1, go to IDLE.
- Per-bin arithmetic:
  - a = |re|, b = |im|, each 17-bit unsigned, so |−32768| = 32768 exactly.
  - mag = max(a,b) + (min(a,b) >> 1), 18-bit, no overflow.
  - s = mag >> SHIFT, then clamped to MAX_HEIGHT.
  - h = committed `bar_heights[i]`; d = (h > DECAY) ? h − DECAY : 0.
  - shadow[i] = max(s, d).
- The snapshot decouples the block from upstream: `frequency_bins` may change at any time after the accept.
- `in_valid` while `in_ready` = 0 is ignored. There is no queuing; the upstream must hold or re-present the frame.
- `bar_heights` is stable between commits. It never shows a partially updated frame.
- Reset has priority over everything, including mid-CALC and COMMIT. On reset:
  - state = IDLE, idx = 0.
  - snapshot, shadow and `bar_heights` = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - An aborted frame produces no `out_valid`.

## Timing
- Accept at the edge ending cycle T.
- CALC occupies cycles T+1 … T+NUM_BINS; COMMIT is cycle T+NUM_BINS+1.
- New `bar_heights` and `out_valid` = 1 are visible in cycle T+NUM_BINS+2 (latency NUM_BINS+2 = 10 at default).
- `in_ready` is 0 in cycles T+1 … T+NUM_BINS+1 and 1 again in T+NUM_BINS+2. A frame may be accepted in that same cycle.
- Maximum throughput: one frame per NUM_BINS+2 cycles. `out_valid` is never high in two consecutive cycles.
- Reset values after the reset edge: `in_ready` = 1, `out_valid` = 0, `bar_heights` = 0.

## Test plan
- **Reset:** assert `reset` 2 cycles with random `in_valid`/`frequency_bins` → all `bar_heights` = 0, `out_valid` = 0, `in_ready` = 1 on the first cycle after reset.
- **Single frame:** bin0 = {0x4000, 0x0000}, bin1 = {0xE000, 0x1000}, bin2 = {0x8000, 0x8000}, rest 0; accept at T → `out_valid` only in T+10; heights 8, 5, 24 (49152>>11 = 24, at clamp), rest 0.
- **Decay / peak hold:** after the previous frame, send an all-zero frame → 7, 4, 23, 0…. Then send bin0 = {0x7000, 0} → bin0 = 14, others decay to 3, 22.
- **Busy drop:** accept frame A, then drive a different frame B with `in_valid` = 1 during T+1…T+9 only → exactly one `out_valid`, reflecting A only.
- **Continuous `in_valid`:** hold `in_valid` = 1 with a constant frame → accepts every 10 cycles, `out_valid` period = 10, no double pulses.
- **Reset mid-CALC:** assert `reset` in cycle T+4 → no `out_valid` for that frame, `bar_heights` = 0, `in_ready` = 1 the cycle after reset. A following frame then yields undecayed values (8, 5, 24 for the single-frame stimulus).
